mem_access_sequencer: RTL and testbench

//  MEM-stage front end of the pipelined CPU, directly upstream of the memory controller.

---
 rtl/mem_access_sequencer.sv | 116 +++++++++++
 tb/tb_mem_access_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: MEM-stage load/store sequencer that sits in front of the memory controller.
// It holds each RAM/serial request for ACCESS_CYCLES cycles, stalls the pipeline while it does so,
// gates UART accesses on the UART status lines, answers the UART status address locally, and
// returns load data to MEM/WB in a register.
// Ports:
//   CLK, RST                 clock (rising edge), asynchronous active-low reset
//   memReadIn, memWriteIn    2-bit load/store codes from EX/MEM (00 = none)
//   addressIn, writeDataIn   effective address and store data from EX/MEM
//   stallOut                 combinational pipeline freeze
//   loadDataOut, loadValid   registered load result, plus a one-cycle pulse when it is new
//   ctrlAddress, ctrlDataOut, ctrlMemRead, ctrlMemWrite   request to the memory controller
//   ctrlDataIn               read data from the memory controller
//   tbre, tsre, data_ready   UART transmit-empty and receive-ready status
module mem_access_sequencer #(
  parameter int unsigned ACCESS_CYCLES = 4,
  parameter logic [15:0] SERIAL_ADDR   = 16'hBF00,
  parameter logic [15:0] STATUS_ADDR   = 16'hBF01
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  memReadIn,
  input  logic [1:0]  memWriteIn,
  input  logic [15:0] addressIn,
  input  logic [15:0] writeDataIn,
  output logic        stallOut,
  output logic [15:0] loadDataOut,
  output logic        loadValid,
  output logic [15:0] ctrlAddress,
  output logic [15:0] ctrlDataOut,
  output logic [1:0]  ctrlMemRead,
  output logic [1:0]  ctrlMemWrite,
  input  logic [15:0] ctrlDataIn,
  input  logic        tbre,
  input  logic        tsre,
  input  logic        data_ready
);
  typedef enum logic [2:0] {IDLE, WAIT_TX, WAIT_RX, BUSY, DONE} state_t;
  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] ldata_q, ldata_d;
  logic [1:0]  code_q, code_d;
  logic        is_wr_q, is_wr_d;
  logic        rd, wr, busy;
  // A request with both codes set is illegal and decodes as neither.
  assign rd   = memReadIn != 2'b00 && memWriteIn == 2'b00;
  assign wr   = memWriteIn != 2'b00 && memReadIn == 2'b00;
  assign busy = state_q == BUSY;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    code_d  = code_q;
    is_wr_d = is_wr_q;
    case (state_q)
      IDLE: if (rd || wr) begin
        addr_d  = addressIn;
        wdata_d = writeDataIn;
        code_d  = rd ? memReadIn : memWriteIn;
        is_wr_d = wr;
        cnt_d   = CNT_INIT;
        if (addressIn == STATUS_ADDR) begin
          state_d = DONE;
          if (rd) ldata_d = {14'b0, data_ready, tbre & tsre};
        end else if (addressIn == SERIAL_ADDR) begin
          state_d = wr ? WAIT_TX : WAIT_RX;
        end else begin
          state_d = BUSY;
        end
      end
      WAIT_TX: state_d = (tbre && tsre) ? BUSY : WAIT_TX;
      WAIT_RX: state_d = data_ready ? BUSY : WAIT_RX;
      BUSY: if (cnt_q == 4'd0) begin
        state_d = DONE;
        if (!is_wr_q) ldata_d = ctrlDataIn;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      ldata_q <= 16'd0;
      code_q  <= 2'b00;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      code_q  <= code_d;
      is_wr_q <= is_wr_d;
    end
  end
  // Controller outputs are decoded from the registered state, so an async reset clears them at once.
  assign ctrlMemRead  = (busy && !is_wr_q) ? code_q : 2'b00;
  assign ctrlMemWrite = (busy && is_wr_q) ? code_q : 2'b00;
  assign ctrlAddress  = busy ? addr_q : 16'd0;
  assign ctrlDataOut  = busy ? wdata_q : 16'd0;
  assign loadDataOut  = ldata_q;
  assign loadValid    = state_q == DONE && !is_wr_q;
  // The RST term keeps the stall low while reset is held, even with a request pending.
  assign stallOut = RST && ((state_q == IDLE && (rd || wr)) || state_q == WAIT_TX ||
                            state_q == WAIT_RX || busy);
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: table-driven and scoreboarded bench for mem_access_sequencer
module tb_mem_access_sequencer;
  localparam int AC = 4;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [1:0] memReadIn, memWriteIn, ctrlMemRead, ctrlMemWrite;
  logic [15:0] addressIn, writeDataIn, loadDataOut, ctrlAddress, ctrlDataOut, ctrlDataIn;
  logic stallOut, loadValid, tbre, tsre, data_ready;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b1;
  int run = 0;
  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [15:0] addr;
    logic [15:0] data;
  } acc_t;
  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] din;
    logic        tbre;
    logic        tsre;
    logic        dr;
    logic        acc;
    int          stall;
    logic        lv;
    logic [15:0] ldo;
  } vec_t;
  acc_t acc_q[$];
  logic [15:0] ld_q[$];
  acc_t cur;
  vec_t vecs[10];
  mem_access_sequencer #(.ACCESS_CYCLES(AC)) dut (
    .CLK(CLK), .RST(RST), .memReadIn(memReadIn), .memWriteIn(memWriteIn),
    .addressIn(addressIn), .writeDataIn(writeDataIn), .stallOut(stallOut),
    .loadDataOut(loadDataOut), .loadValid(loadValid), .ctrlAddress(ctrlAddress),
    .ctrlDataOut(ctrlDataOut), .ctrlMemRead(ctrlMemRead), .ctrlMemWrite(ctrlMemWrite),
    .ctrlDataIn(ctrlDataIn), .tbre(tbre), .tsre(tsre), .data_ready(data_ready)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Scoreboard: each controller run must match the next queued access, stay stable and last AC cycles;
  // each loadValid pulse must carry the next queued load value.
  always @(negedge CLK) begin
    if (!mon_en) begin
      run = 0;
    end else begin
      if (ctrlMemRead != 2'b00 || ctrlMemWrite != 2'b00) begin
        if (run == 0) begin
          if (acc_q.size() == 0) begin
            chk("acc_unexpected", 64'(acc_q.size()), 64'd1);
            cur = '{ctrlMemRead, ctrlMemWrite, ctrlAddress, ctrlDataOut};
          end else begin
            cur = acc_q.pop_front();
          end
        end
        chk("acc_fields", {ctrlMemRead, ctrlMemWrite, ctrlAddress, ctrlDataOut},
            {cur.rd, cur.wr, cur.addr, cur.data});
        run++;
      end else if (run != 0) begin
        chk("acc_len", 64'(run), 64'(AC));
        run = 0;
      end
      if (loadValid) begin
        if (ld_q.size() == 0) chk("load_unexpected", 64'(loadDataOut), 64'hFFFF_FFFF);
        else chk("load_data_sb", loadDataOut, ld_q.pop_front());
      end
    end
  end
  task automatic clear_req();
    memReadIn   = 2'b00;
    memWriteIn  = 2'b00;
    addressIn   = 16'hBF01;
    writeDataIn = 16'hDEAD;
  endtask
  task automatic run_vec(input vec_t v);
    int n;
    memReadIn = v.rd; memWriteIn = v.wr; addressIn = v.addr; writeDataIn = v.wdata;
    ctrlDataIn = v.din; tbre = v.tbre; tsre = v.tsre; data_ready = v.dr;
    if (v.acc) acc_q.push_back('{v.rd, v.wr, v.addr, v.wdata});
    if (v.lv) ld_q.push_back(v.ldo);
    n = 0;
    @(negedge CLK);
    while (stallOut && n < 50) begin
      n++;
      @(posedge CLK); #1;
      clear_req();
      @(negedge CLK);
    end
    chk("stall_cycles", 64'(n), 64'(v.stall));
    chk("load_valid", 64'(loadValid), 64'(v.lv));
    chk("load_data", loadDataOut, v.ldo);
    @(posedge CLK); #1;
    clear_req();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n;
    memReadIn = 2'b01; memWriteIn = 2'b00; addressIn = 16'h0040; writeDataIn = 16'h0;
    ctrlDataIn = 16'h0; tbre = 1'b1; tsre = 1'b1; data_ready = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset_stall", 64'(stallOut), 64'd0);
    chk("reset_outputs", {loadValid, loadDataOut, ctrlMemRead, ctrlMemWrite, ctrlAddress, ctrlDataOut}, 64'd0);
    clear_req();
    RST = 1'b1;
    @(posedge CLK); #1;
    //        rd     wr     addr      wdata     din       tbre  tsre  dr    acc   stall lv    ldo
    vecs[0] = '{2'b01, 2'b00, 16'h0040, 16'h0000, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b1, 5, 1'b1, 16'h1234};
    vecs[1] = '{2'b00, 2'b01, 16'h0041, 16'hBEEF, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 5, 1'b0, 16'h1234};
    vecs[2] = '{2'b10, 2'b00, 16'h1000, 16'h0000, 16'hA5A5, 1'b1, 1'b1, 1'b0, 1'b1, 5, 1'b1, 16'hA5A5};
    vecs[3] = '{2'b01, 2'b00, 16'hBF01, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1, 16'h0002};
    vecs[4] = '{2'b01, 2'b00, 16'hBF01, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b1, 16'h0003};
    vecs[5] = '{2'b00, 2'b01, 16'hBF01, 16'h5555, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 16'h0003};
    vecs[6] = '{2'b01, 2'b01, 16'h0050, 16'h1111, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'h0003};
    vecs[7] = '{2'b00, 2'b10, 16'hBF00, 16'h0041, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 6, 1'b0, 16'h0003};
    vecs[8] = '{2'b01, 2'b00, 16'hBF00, 16'h0000, 16'h0055, 1'b1, 1'b1, 1'b1, 1'b1, 6, 1'b1, 16'h0055};
    vecs[9] = '{2'b00, 2'b00, 16'h0040, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'h0055};
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);
    // Serial store held off by tsre=0 for six cycles
    memWriteIn = 2'b01; addressIn = 16'hBF00; writeDataIn = 16'h7777; tbre = 1'b1; tsre = 1'b0;
    acc_q.push_back('{2'b00, 2'b01, 16'hBF00, 16'h7777});
    @(negedge CLK);
    chk("wait_tx_accept", 64'(stallOut), 64'd1);
    @(posedge CLK); #1;
    clear_req();
    repeat (6) begin
      @(negedge CLK);
      chk("wait_tx_hold", {stallOut, ctrlMemRead, ctrlMemWrite}, 64'b10000);
    end
    @(posedge CLK); #1;
    tsre = 1'b1;
    @(negedge CLK);
    n = 0;
    while (stallOut && n < 50) begin
      n++;
      @(negedge CLK);
    end
    chk("wait_tx_release", 64'(n), 64'd5);
    chk("wait_tx_no_valid", 64'(loadValid), 64'd0);
    @(posedge CLK); #1;
    // Reset in the second BUSY cycle aborts the access
    mon_en = 1'b0;
    memReadIn = 2'b01; addressIn = 16'h0040; ctrlDataIn = 16'h9999;
    @(posedge CLK); #1;
    clear_req();
    @(posedge CLK); #1;
    chk("busy_before_reset", 64'(ctrlMemRead), 64'd1);
    RST = 1'b0;
    #1;
    chk("reset_abort", {ctrlMemRead, ctrlMemWrite, stallOut}, 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("post_reset", {stallOut, loadValid, ctrlMemRead, ctrlMemWrite, loadDataOut}, 64'd0);
    @(posedge CLK); #1;
    mon_en = 1'b1;
    run_vec(vecs[0]);
    chk("scoreboard_drain", 64'(acc_q.size() + ld_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
